// File: rtl/mux2_pkg.sv
// Shared constants for the registered 2:1 mux and its optional select synchronizer.
package mux2_pkg;

  localparam int MUX2_DEF_WIDTH = 1;

  localparam logic SEL_A = 1'b1;
  localparam logic SEL_B = 1'b0;

  // Only a clean 1 picks in_a; 0, X and Z all fall back to in_b.
  function automatic logic sel_is_a(input logic sel);
    logic result;
    result = SEL_B;
    if (sel == SEL_A) begin
      result = SEL_A;
    end
    return result;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop single-bit synchronizer with synchronous active-low reset to 0.
module sync_2ff
  import mux2_pkg::*;
(
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic meta_d;
  logic sync_q;
  logic sync_d;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      meta_q <= SEL_B;
      sync_q <= SEL_B;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/mux2_sync.sv
// Registered 2:1 mux: out <= sel ? in_a : in_b on each sys_clk edge.
// Define MUX2_SYNC_SEL_SYNC_EN to pass sel through a 2-flop synchronizer first.
module mux2_sync
  import mux2_pkg::*;
#(
  parameter int               WIDTH   = MUX2_DEF_WIDTH,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             sel,
  output logic [WIDTH-1:0] out,
  output logic             sel_q
);

  logic             sel_eff;
  logic [WIDTH-1:0] out_q;
  logic [WIDTH-1:0] out_d;
  logic             sel_applied_q;
  logic             sel_applied_d;

  generate
`ifdef MUX2_SYNC_SEL_SYNC_EN
    sync_2ff u_sel_sync (
      .sys_clk   (sys_clk),
      .sys_rst_n (sys_rst_n),
      .d         (sel),
      .q         (sel_eff)
    );
`else
    assign sel_eff = sel;
`endif
  endgenerate

  always_comb begin
    out_d         = in_b;
    sel_applied_d = SEL_B;
    if (sel_is_a(sel_eff) == SEL_A) begin
      out_d         = in_a;
      sel_applied_d = SEL_A;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      out_q         <= RST_VAL;
      sel_applied_q <= SEL_B;
    end else begin
      out_q         <= out_d;
      sel_applied_q <= sel_applied_d;
    end
  end

  assign out   = out_q;
  assign sel_q = sel_applied_q;

endmodule

// File: tb/tb_mux2_sync.sv
// Self-checking bench for mux2_sync (WIDTH=1 and WIDTH=8 instances); honours MUX2_SYNC_SEL_SYNC_EN.
module tb_mux2_sync;

`ifdef MUX2_SYNC_SEL_SYNC_EN
  localparam int SEL_LAG = 2;
`else
  localparam int SEL_LAG = 0;
`endif

  logic       sys_clk;
  logic       sys_rst_n;
  logic       sel;
  logic [0:0] in_a1, in_b1, out1;
  logic [7:0] in_a8, in_b8, out8;
  logic       sel_q1, sel_q8;

  int n_compared   = 0;
  int n_mismatched = 0;

  // Per-edge history of what was presented; expectations are derived from it.
  bit       sel_log[$];
  bit       rst_log[$];
  bit [0:0] a1_log[$], b1_log[$];
  bit [7:0] a8_log[$], b8_log[$];

  logic [0:0] exp_out1;
  logic [7:0] exp_out8;
  logic       exp_selq;

  mux2_sync #(.WIDTH(1)) dut1 (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .in_a(in_a1), .in_b(in_b1),
    .sel(sel), .out(out1), .sel_q(sel_q1)
  );

  mux2_sync #(.WIDTH(8), .RST_VAL(8'hA5)) dut8 (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .in_a(in_a8), .in_b(in_b8),
    .sel(sel), .out(out8), .sel_q(sel_q8)
  );

  initial sys_clk = 1'b0;
  always #10 sys_clk = ~sys_clk;

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Drive one cycle of inputs, take the edge, then predict from the history:
  // reset wins; otherwise the select seen SEL_LAG edges ago picks this edge's data,
  // with any reset inside that window forcing the select to in_b.
  task automatic drive_edge(input bit a1, input bit b1, input bit s, input bit rst,
                            input bit [7:0] a8, input bit [7:0] b8);
    int  n;
    bit  applied;
    @(negedge sys_clk);
    in_a1 = a1; in_b1 = b1; sel = s; sys_rst_n = ~rst;
    in_a8 = a8; in_b8 = b8;
    @(posedge sys_clk);
    #1;
    sel_log.push_back(s);  rst_log.push_back(rst);
    a1_log.push_back(a1);  b1_log.push_back(b1);
    a8_log.push_back(a8);  b8_log.push_back(b8);
    n = sel_log.size() - 1;
    if (rst) begin
      exp_out1 = 1'b0;
      exp_out8 = 8'hA5;
      exp_selq = 1'b0;
    end else begin
      if (n < SEL_LAG) applied = 1'b0;
      else begin
        applied = sel_log[n - SEL_LAG];
        for (int k = n - SEL_LAG; k < n; k++) if (rst_log[k]) applied = 1'b0;
      end
      exp_out1 = applied ? a1_log[n] : b1_log[n];
      exp_out8 = applied ? a8_log[n] : b8_log[n];
      exp_selq = applied;
    end
  endtask

  task automatic test_reset();
    drive_edge(1'b1, 1'b0, 1'b1, 1'b1, 8'h3C, 8'hC3);
    drive_edge(1'b1, 1'b0, 1'b1, 1'b1, 8'h3C, 8'hC3);
    n_compared++;
    if (out1 !== 1'b0) begin
      n_mismatched++; $display("[TB] FAIL reset_out: got %0h expected 0", out1);
    end
    n_compared++;
    if (sel_q1 !== 1'b0) begin
      n_mismatched++; $display("[TB] FAIL reset_sel_q: got %0h expected 0", sel_q1);
    end
    n_compared++;
    if (out8 !== 8'hA5) begin
      n_mismatched++; $display("[TB] FAIL reset_out8: got %0h expected a5", out8);
    end
  endtask

  task automatic test_truth_table();
    bit tbl [4][3] = '{'{1,0,1}, '{1,0,0}, '{0,1,1}, '{0,1,0}};
    for (int i = 0; i < 4; i++) begin
      drive_edge(tbl[i][0], tbl[i][1], tbl[i][2], 1'b0, 8'h00, 8'hFF);
      n_compared++;
      if (out1 !== exp_out1) begin
        n_mismatched++;
        $display("[TB] FAIL truth_table[%0d]: got %0h expected %0h", i, out1, exp_out1);
      end
      n_compared++;
      if (sel_q1 !== exp_selq) begin
        n_mismatched++;
        $display("[TB] FAIL truth_sel_q[%0d]: got %0h expected %0h", i, sel_q1, exp_selq);
      end
    end
  endtask

  task automatic test_toggle();
    for (int i = 0; i < 8; i++) begin
      drive_edge(1'b1, 1'b0, bit'(i % 2 == 0), 1'b0, 8'h0F, 8'hF0);
      n_compared++;
      if (out1 !== exp_out1) begin
        n_mismatched++;
        $display("[TB] FAIL toggle[%0d]: got %0h expected %0h", i, out1, exp_out1);
      end
      n_compared++;
      if (out8 !== exp_out8) begin
        n_mismatched++;
        $display("[TB] FAIL toggle_out8[%0d]: got %0h expected %0h", i, out8, exp_out8);
      end
    end
  endtask

  task automatic test_reset_midstream();
    for (int i = 0; i < 3; i++) drive_edge(1'b1, 1'b0, 1'b1, 1'b0, 8'h11, 8'h22);
    n_compared++;
    if (out1 !== 1'b1) begin
      n_mismatched++; $display("[TB] FAIL midstream_pre: got %0h expected 1", out1);
    end
    drive_edge(1'b1, 1'b0, 1'b1, 1'b1, 8'h11, 8'h22);
    n_compared++;
    if (out1 !== 1'b0 || out8 !== 8'hA5) begin
      n_mismatched++;
      $display("[TB] FAIL midstream_rst: got %0h/%0h expected 0/a5", out1, out8);
    end
    drive_edge(1'b1, 1'b0, 1'b1, 1'b0, 8'h11, 8'h22);
    n_compared++;
    if (out1 !== exp_out1 || out8 !== exp_out8) begin
      n_mismatched++;
      $display("[TB] FAIL midstream_release: got %0h/%0h expected %0h/%0h",
               out1, out8, exp_out1, exp_out8);
    end
  endtask

  task automatic test_width8();
    for (int i = 0; i < 6; i++) begin
      drive_edge(1'b0, 1'b0, bit'(i >= 3), 1'b0, 8'h3C, 8'hC3);
      n_compared++;
      if (out8 !== exp_out8) begin
        n_mismatched++;
        $display("[TB] FAIL width8[%0d]: got %0h expected %0h", i, out8, exp_out8);
      end
    end
  endtask

  task automatic test_equal_inputs();
    for (int i = 0; i < 4; i++) begin
      drive_edge(1'b1, 1'b1, bit'($urandom_range(1)), 1'b0, 8'h5A, 8'h5A);
      n_compared++;
      if (out1 !== 1'b1 || out8 !== 8'h5A) begin
        n_mismatched++;
        $display("[TB] FAIL equal_inputs[%0d]: got %0h/%0h expected 1/5a", i, out1, out8);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      drive_edge(bit'($urandom_range(1)), bit'($urandom_range(1)), bit'($urandom_range(1)),
                 bit'($urandom_range(15) == 0), 8'($urandom), 8'($urandom));
      n_compared++;
      if (out1 !== exp_out1 || sel_q1 !== exp_selq) begin
        n_mismatched++;
        $display("[TB] FAIL random[%0d]: got out=%0h sel_q=%0h expected out=%0h sel_q=%0h",
                 i, out1, sel_q1, exp_out1, exp_selq);
      end
      n_compared++;
      if (out8 !== exp_out8 || sel_q8 !== exp_selq) begin
        n_mismatched++;
        $display("[TB] FAIL random8[%0d]: got out=%0h sel_q=%0h expected out=%0h sel_q=%0h",
                 i, out8, sel_q8, exp_out8, exp_selq);
      end
    end
  endtask

`ifdef MUX2_SYNC_SEL_SYNC_EN
  task automatic test_sel_sync();
    bit expect_rise [3] = '{1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 4; i++) drive_edge(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    for (int i = 0; i < 3; i++) begin
      drive_edge(1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00);
      n_compared++;
      if (out1 !== expect_rise[i]) begin
        n_mismatched++;
        $display("[TB] FAIL sel_sync_edge%0d: got %0h expected %0h", i + 1, out1, expect_rise[i]);
      end
    end
    drive_edge(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00);
    n_compared++;
    if (out1 !== 1'b0) begin
      n_mismatched++; $display("[TB] FAIL sel_sync_data: got %0h expected 0", out1);
    end
  endtask
`endif

  initial begin
    sys_rst_n = 1'b0; sel = 1'b0;
    in_a1 = '0; in_b1 = '0; in_a8 = '0; in_b8 = '0;
    test_reset();
    test_truth_table();
    test_toggle();
    test_reset_midstream();
    test_width8();
    test_equal_inputs();
`ifdef MUX2_SYNC_SEL_SYNC_EN
    test_sel_sync();
`endif
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
